// File: rtl/rx_stream_xor.sv
// Receive-path payload unit: XORs an AXI-Stream payload with a handshaked keystream
// word, buffers results in a 2-entry output FIFO and tracks frame protocol errors.
module rx_stream_xor #(
  parameter int DATA_WIDTH = 32,
  parameter int KS_DEPTH   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic                  i_enable,
  input  logic                  i_bypass,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_sof,
  input  logic                  s_axis_eof,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] ks_tdata,
  input  logic                  ks_tvalid,
  output logic                  ks_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_sof,
  output logic                  m_axis_eof,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  o_frame_count,
  output logic [CNT_WIDTH-1:0]  o_error_count,
  output logic                  o_error,
  output logic                  o_frame_state
);

  // Handshake rule on every port: a word moves on a clock edge where valid && ready
  // are both 1; valid never waits on ready, and ready never depends on m_axis_tready.

  localparam int KS_AW = $clog2(KS_DEPTH);
  localparam logic [KS_AW:0] KS_FULL = (KS_AW+1)'(KS_DEPTH);

  typedef enum logic {IDLE, IN_FRAME} frame_state_t;

  logic [DATA_WIDTH-1:0] ks_mem [KS_DEPTH];
  logic [KS_AW-1:0]      ks_wr_ptr, ks_rd_ptr;
  logic [KS_AW:0]        ks_count;
  logic [DATA_WIDTH-1:0] ks_head;

  logic [DATA_WIDTH+1:0] ob_mem [2];
  logic                  ob_wr_ptr, ob_rd_ptr;
  logic [1:0]            ob_count;
  logic [DATA_WIDTH+1:0] ob_word;

  logic accept, ks_push, ks_pop, ob_pop;
  logic frame_inc, proto_err;
  frame_state_t state_q, state_d;

  assign ks_tready = !i_areset && (ks_count < KS_FULL) && !i_flush;
  // A keystream word pushed this cycle is not yet usable, so only the registered count counts.
  assign s_axis_tready = !i_areset && i_enable && (ob_count != 2'd2) &&
                         (i_bypass || ((ks_count != '0) && !i_flush));

  assign accept  = s_axis_tvalid && s_axis_tready;
  assign ks_push = ks_tvalid && ks_tready;
  assign ks_pop  = accept && !i_bypass;
  assign ob_pop  = m_axis_tvalid && m_axis_tready;
  assign ks_head = ks_mem[ks_rd_ptr];
  assign ob_word = {(i_bypass ? s_axis_tdata : (s_axis_tdata ^ ks_head)), s_axis_sof, s_axis_eof};

  always_ff @(posedge i_aclk) begin
    if (ks_push) ks_mem[ks_wr_ptr] <= ks_tdata;
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      ks_wr_ptr <= '0;
      ks_rd_ptr <= '0;
      ks_count  <= '0;
    end else if (i_flush) begin
      ks_wr_ptr <= '0;
      ks_rd_ptr <= '0;
      ks_count  <= '0;
    end else begin
      if (ks_push) ks_wr_ptr <= ks_wr_ptr + KS_AW'(1);
      if (ks_pop)  ks_rd_ptr <= ks_rd_ptr + KS_AW'(1);
      case ({ks_push, ks_pop})
        2'b10:   ks_count <= ks_count + (KS_AW+1)'(1);
        2'b01:   ks_count <= ks_count - (KS_AW+1)'(1);
        default: ks_count <= ks_count;
      endcase
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      ob_mem[0] <= '0;
      ob_mem[1] <= '0;
      ob_wr_ptr <= 1'b0;
      ob_rd_ptr <= 1'b0;
      ob_count  <= 2'd0;
    end else begin
      if (accept) begin
        ob_mem[ob_wr_ptr] <= ob_word;
        ob_wr_ptr         <= ~ob_wr_ptr;
      end
      if (ob_pop) ob_rd_ptr <= ~ob_rd_ptr;
      case ({accept, ob_pop})
        2'b10:   ob_count <= ob_count + 2'd1;
        2'b01:   ob_count <= ob_count - 2'd1;
        default: ob_count <= ob_count;
      endcase
    end
  end

  assign m_axis_tvalid = (ob_count != 2'd0);
  assign {m_axis_tdata, m_axis_sof, m_axis_eof} = m_axis_tvalid ? ob_mem[ob_rd_ptr] : '0;

  always_comb begin
    state_d   = state_q;
    frame_inc = 1'b0;
    proto_err = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (s_axis_sof && s_axis_eof) frame_inc = 1'b1;
          else if (s_axis_sof)          state_d   = IN_FRAME;
          else                          proto_err = 1'b1;
        end
        IN_FRAME: begin
          // A sof inside a frame restarts it; the word is still forwarded.
          if (s_axis_sof) proto_err = 1'b1;
          if (s_axis_eof) begin
            frame_inc = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q       <= IDLE;
      o_frame_count <= '0;
      o_error_count <= '0;
      o_error       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_inc) o_frame_count <= o_frame_count + CNT_WIDTH'(1);
      if (proto_err && (o_error_count != '1)) o_error_count <= o_error_count + CNT_WIDTH'(1);
      // A new error in the flush cycle wins, so it is never silently lost.
      if (proto_err)    o_error <= 1'b1;
      else if (i_flush) o_error <= 1'b0;
    end
  end

  assign o_frame_state = (state_q == IN_FRAME);

endmodule

// File: tb/tb_rx_stream_xor.sv
// Bench for rx_stream_xor: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_rx_stream_xor;
  localparam int W  = 32;
  localparam int KD = 4;
  localparam int CW = 16;

  logic          i_aclk = 1'b0;
  logic          i_areset = 1'b1;
  logic          i_enable = 1'b0, i_bypass = 1'b0, i_flush = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_sof = 1'b0, s_axis_eof = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  ks_tdata = '0;
  logic          ks_tvalid = 1'b0, ks_tready;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid, m_axis_sof, m_axis_eof;
  logic          m_axis_tready = 1'b0;
  logic [CW-1:0] o_frame_count, o_error_count;
  logic          o_error, o_frame_state;

  rx_stream_xor #(.DATA_WIDTH(W), .KS_DEPTH(KD), .CNT_WIDTH(CW)) dut (
    .i_aclk(i_aclk), .i_areset(i_areset), .i_enable(i_enable), .i_bypass(i_bypass),
    .i_flush(i_flush), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_sof(s_axis_sof), .s_axis_eof(s_axis_eof), .s_axis_tready(s_axis_tready),
    .ks_tdata(ks_tdata), .ks_tvalid(ks_tvalid), .ks_tready(ks_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_sof(m_axis_sof),
    .m_axis_eof(m_axis_eof), .m_axis_tready(m_axis_tready), .o_frame_count(o_frame_count),
    .o_error_count(o_error_count), .o_error(o_error), .o_frame_state(o_frame_state)
  );

  // clock / reset
  always #5 i_aclk = ~i_aclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: queues of keystream words and expected output words
  logic [W-1:0]   mks_q[$];
  logic [W+1:0]   exp_q[$];
  logic           m_in_frame = 1'b0;
  logic [CW-1:0]  m_frames = '0, m_errs = '0;
  logic           m_err = 1'b0;

  function automatic logic exp_s_ready();
    return !i_areset && i_enable && (exp_q.size() < 2) &&
           (i_bypass || (mks_q.size() > 0 && !i_flush));
  endfunction

  function automatic logic exp_ks_ready();
    return !i_areset && (mks_q.size() < KD) && !i_flush;
  endfunction

  always @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      mks_q.delete();
      exp_q.delete();
      m_in_frame = 1'b0;
      m_frames   = '0;
      m_errs     = '0;
      m_err      = 1'b0;
    end else begin
      logic acc, kpush, opop, err_evt;
      logic [W-1:0] res;
      acc     = s_axis_tvalid && exp_s_ready();
      kpush   = ks_tvalid && exp_ks_ready();
      opop    = (exp_q.size() > 0) && m_axis_tready;
      err_evt = 1'b0;
      res     = s_axis_tdata;
      if (acc && !i_bypass) res = s_axis_tdata ^ mks_q.pop_front();
      if (opop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({res, s_axis_sof, s_axis_eof});
      if (i_flush) mks_q.delete();
      if (kpush) mks_q.push_back(ks_tdata);
      if (acc) begin
        if (!m_in_frame) begin
          if (s_axis_sof && s_axis_eof) m_frames++;
          else if (s_axis_sof)          m_in_frame = 1'b1;
          else                          err_evt = 1'b1;
        end else begin
          if (s_axis_sof) err_evt = 1'b1;
          if (s_axis_eof) begin
            m_frames++;
            m_in_frame = 1'b0;
          end
        end
      end
      if (err_evt) begin
        m_err = 1'b1;
        if (m_errs != '1) m_errs++;
      end else if (i_flush) begin
        m_err = 1'b0;
      end
    end
  end

  // scoreboard: compare every cycle on the falling edge, capture delivered words
  logic [W+1:0] got_q[$];

  task automatic chk_reset_values(input string tag);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_ks_tready"}, ks_tready, 0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 0);
    chk({tag, "_m_flags"}, {m_axis_sof, m_axis_eof}, 0);
    chk({tag, "_frames"}, o_frame_count, 0);
    chk({tag, "_errs"}, o_error_count, 0);
    chk({tag, "_error"}, o_error, 0);
    chk({tag, "_state"}, o_frame_state, 0);
  endtask

  always @(negedge i_aclk) begin
    if (i_areset) begin
      chk_reset_values("rst");
    end else begin
      chk("s_tready", s_axis_tready, exp_s_ready());
      chk("ks_tready", ks_tready, exp_ks_ready());
      chk("m_tvalid", m_axis_tvalid, exp_q.size() != 0);
      if (exp_q.size() != 0)
        chk("m_word", {m_axis_tdata, m_axis_sof, m_axis_eof}, exp_q[0]);
      chk("frames", o_frame_count, m_frames);
      chk("errs", o_error_count, m_errs);
      chk("error", o_error, m_err);
      chk("state", o_frame_state, m_in_frame);
      if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tdata, m_axis_sof, m_axis_eof});
    end
  end

  // driver: streams held until handshake
  logic [W+1:0] tx_q[$];
  logic [W-1:0] ks_tx[$];

  task automatic load();
    s_axis_tvalid = (tx_q.size() > 0);
    if (tx_q.size() > 0) {s_axis_tdata, s_axis_sof, s_axis_eof} = tx_q[0];
    ks_tvalid = (ks_tx.size() > 0);
    if (ks_tx.size() > 0) ks_tdata = ks_tx[0];
  endtask

  task automatic step();
    logic s_hs, k_hs;
    @(negedge i_aclk);
    s_hs = s_axis_tvalid && s_axis_tready;
    k_hs = ks_tvalid && ks_tready;
    @(posedge i_aclk);
    #1;
    if (s_hs) void'(tx_q.pop_front());
    if (k_hs) void'(ks_tx.pop_front());
    load();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [W+1:0] next_got();
    if (got_q.size() == 0) return 'x;
    return got_q.pop_front();
  endfunction

  task automatic do_reset(input string tag);
    tx_q.delete();
    ks_tx.delete();
    load();
    i_flush  = 1'b0;
    i_areset = 1'b1;
    repeat (2) @(posedge i_aclk);
    #1;
    chk_reset_values(tag);
    i_areset = 1'b0;
    got_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic XOR
    i_enable = 1'b1;
    m_axis_tready = 1'b1;
    do_reset("t1_reset");
    ks_tx.push_back(32'hFFFF0000);
    ks_tx.push_back(32'h12345678);
    tx_q.push_back({32'h0000FFFF, 1'b1, 1'b0});
    tx_q.push_back({32'h12345678, 1'b0, 1'b1});
    load();
    steps(10);
    chk("t1_w0", next_got(), {32'hFFFFFFFF, 1'b1, 1'b0});
    chk("t1_w1", next_got(), {32'h00000000, 1'b0, 1'b1});
    chk("t1_frames", o_frame_count, 1);
    chk("t1_error", o_error, 0);

    // keystream starvation
    do_reset("t2_reset");
    tx_q.push_back({32'hCAFEBABE, 1'b1, 1'b0});
    tx_q.push_back({32'h11111111, 1'b0, 1'b1});
    load();
    steps(3);
    chk("t2_starved_tready", s_axis_tready, 0);
    chk("t2_starved_pending", tx_q.size(), 2);
    ks_tx.push_back(32'h0F0F0F0F);
    load();
    step();
    chk("t2_ks_in_tready", s_axis_tready, 1);
    chk("t2_ks_in_pending", tx_q.size(), 2);
    steps(4);
    chk("t2_one_accepted", tx_q.size(), 1);
    chk("t2_word", next_got(), {32'hC5F1B5B1, 1'b1, 1'b0});
    chk("t2_no_extra", got_q.size(), 0);

    // back-pressure
    do_reset("t3_reset");
    i_bypass = 1'b1;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) tx_q.push_back({W'(32'h100 + i), i == 0, i == 4});
    load();
    steps(8);
    chk("t3_accepted_two", tx_q.size(), 3);
    chk("t3_tready_low", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    steps(12);
    for (int i = 0; i < 5; i++) chk("t3_order", next_got(), {W'(32'h100 + i), i == 0, i == 4});
    chk("t3_no_dup", got_q.size(), 0);

    // protocol errors
    do_reset("t4_reset");
    tx_q.push_back({32'h1, 1'b1, 1'b0});
    tx_q.push_back({32'h2, 1'b1, 1'b0});
    tx_q.push_back({32'h3, 1'b0, 1'b1});
    load();
    steps(8);
    chk("t4_error", o_error, 1);
    chk("t4_errs", o_error_count, 1);
    chk("t4_frames", o_frame_count, 1);
    tx_q.push_back({32'h4, 1'b0, 1'b1});
    load();
    steps(4);
    chk("t4_lone_eof_errs", o_error_count, 2);
    chk("t4_lone_eof_frames", o_frame_count, 1);

    // flush then bypass
    i_bypass = 1'b0;
    do_reset("t5_reset");
    for (int i = 0; i < 3; i++) ks_tx.push_back(W'(32'hABC0 + i));
    load();
    steps(4);
    chk("t5_ks_loaded_ready", ks_tready, 1);
    chk("t5_ks_loaded_s_ready", s_axis_tready, 1);
    i_flush = 1'b1;
    #1;
    chk("t5_flush_ks_ready", ks_tready, 0);
    step();
    i_flush = 1'b0;
    #1;
    chk("t5_after_flush_tready", s_axis_tready, 0);
    chk("t5_after_flush_ks_ready", ks_tready, 1);
    i_bypass = 1'b1;
    tx_q.push_back({32'hA5A5A5A5, 1'b1, 1'b1});
    load();
    steps(4);
    chk("t5_bypass_word", next_got(), {32'hA5A5A5A5, 1'b1, 1'b1});

    // reset mid-frame with a full output buffer
    do_reset("t6_reset");
    m_axis_tready = 1'b0;
    tx_q.push_back({32'h10, 1'b1, 1'b0});
    tx_q.push_back({32'h11, 1'b0, 1'b0});
    tx_q.push_back({32'h12, 1'b0, 1'b0});
    load();
    steps(4);
    chk("t6_full_pending", tx_q.size(), 1);
    chk("t6_full_valid", m_axis_tvalid, 1);
    #2;
    i_areset = 1'b1;
    #1;
    chk_reset_values("t6_async");
    tx_q.delete();
    load();
    @(posedge i_aclk);
    #1;
    i_areset = 1'b0;
    m_axis_tready = 1'b1;
    got_q.delete();
    tx_q.push_back({32'h77, 1'b1, 1'b1});
    load();
    steps(3);
    chk("t6_error_clear", o_error, 0);
    chk("t6_frames", o_frame_count, 1);
    chk("t6_word", next_got(), {32'h77, 1'b1, 1'b1});

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      i_enable      = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) i_bypass = ~i_bypass;
      i_flush       = ($urandom_range(0, 59) == 0);
      while (tx_q.size() < 2)
        tx_q.push_back({W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
      if (ks_tx.size() < 2 && $urandom_range(0, 3) != 0) ks_tx.push_back(W'($urandom));
      load();
      step();
    end
    i_flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
